output_module: RTL

OUTPUT_MODULE -- requirements
Module: output_module

---
 rtl/output_module_if.sv | 25 ++
 rtl/output_module.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/output_module_if.sv
// Bus between the merge-tree output stage and its producer/consumer.
// The producer side (master) drives elements, flush requests and the
// downstream ready; the output stage (slave) answers with back-pressure,
// packed blocks and status.
interface output_module_if;
    logic [31:0]  din;
    logic         din_valid;
    logic         full;
    logic         flush;
    logic [511:0] dout;
    logic         dout_valid;
    logic         dout_rdy;
    logic         flush_busy;
    logic [15:0]  blk_cnt;

    modport master (
        output din, din_valid, flush, dout_rdy,
        input  full, dout, dout_valid, flush_busy, blk_cnt
    );

    modport slave (
        input  din, din_valid, flush, dout_rdy,
        output full, dout, dout_valid, flush_busy, blk_cnt
    );
endinterface

// File: rtl/output_module.sv
// Packs 32-bit sorted elements into 512-bit blocks, first element in the
// lowest lane, and queues finished blocks in a two-entry output FIFO.
// A flush closes a partial block, padding the unused lanes with PAD; the
// padded block waits in a pending state until the FIFO has room.
module output_module #(
    parameter int          ELEMS = 16,
    parameter logic [31:0] PAD   = 32'hFFFFFFFF
) (
    input  logic           clk,
    input  logic           rst,
    output_module_if.slave bus
);

    typedef enum logic {
        IDLE,
        PENDING
    } flush_state_t;

    flush_state_t state;
    flush_state_t state_next;

    logic [3:0]   cnt;
    logic [3:0]   cnt_next;
    logic [3:0]   cnt_after;
    logic [31:0]  lanes [ELEMS];

    logic [511:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   occ;
    logic [15:0]  blk_cnt;

    logic         accept;
    logic         deq;
    logic         space;
    logic         push_full;
    logic         push_pad;
    logic         push;
    logic [511:0] full_block;
    logic [511:0] pad_block;
    logic [511:0] push_data;

    // Handshake decodes; full depends on registered state only so the
    // producer never sees a combinational loop through din_valid or flush.
    assign accept    = bus.din_valid && !bus.full;
    assign deq       = bus.dout_valid && bus.dout_rdy;
    assign space     = (occ != 2'd2) || deq;
    assign cnt_after = accept ? cnt + 4'd1 : cnt;
    assign push_full = accept && (cnt == 4'd15);
    assign push      = push_full || push_pad;
    assign push_data = push_pad ? pad_block : full_block;

    assign bus.full       = (occ == 2'd2) || ((state == PENDING) && (cnt != 4'd0));
    assign bus.flush_busy = (state == PENDING);
    assign bus.dout_valid = (occ != 2'd0);
    assign bus.dout       = mem[rd_ptr];
    assign bus.blk_cnt    = blk_cnt;

    // Assemble the two candidate blocks: a complete one whose top lane is the
    // element arriving now, and a padded one built from the stored lanes.
    always_comb begin
        full_block = '0;
        pad_block  = '0;
        for (int i = 0; i < ELEMS; i++) begin
            full_block[32*i +: 32] = (i == ELEMS - 1) ? bus.din : lanes[i];
            pad_block[32*i +: 32]  = (i < int'(cnt)) ? lanes[i] : PAD;
        end
    end

    // Flush control: a flush that leaves lanes filled parks the partial block
    // in PENDING, which holds off new elements until the block is pushed.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        push_pad   = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = cnt_after;
                if (bus.flush && (cnt_after != 4'd0)) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (space) begin
                    push_pad   = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Flush state and lane counter; reset discards any partial block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Lane storage needs no reset: the counter decides which lanes are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            lanes[cnt] <= bus.din;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, deq})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // FIFO storage; contents are meaningless until the first push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Running count of blocks handed downstream, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= 16'd0;
        end else if (deq) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end

endmodule
